// File: rtl/cpu_reset_sequencer_pkg.sv
// Shared types and defaults for the CPU reset sequencer.
// State encoding, default timing constants and width helpers.
package cray_reset_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SELECT,
    HOLD,
    GAP,
    WAIT
  } seq_state_e;

  localparam int unsigned DEF_NCPU        = 4;
  localparam int unsigned DEF_HOLD_CYCLES = 8;
  localparam int unsigned DEF_GAP_CYCLES  = 4;
  localparam int unsigned DEF_ACK_TIMEOUT = 255;

  // Counter width covering the largest reload value (max - 1).
  function automatic int unsigned cnt_width(input int unsigned a,
                                            input int unsigned b,
                                            input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

  // Width of a CPU index.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/cpu_reset_sequencer_if.sv
// Request/response bundle between the reset sequencer, the
// maintenance channel and the CPU array.
interface cpu_reset_sequencer_if #(
  parameter int unsigned NCPU = 4
);
  logic [NCPU-1:0] REQ_RESET;
  logic            REQ_ALL;
  logic [NCPU-1:0] CPU_RESET;
  logic [NCPU-1:0] CPU_START;
  logic [NCPU-1:0] CPU_READY;
  logic [NCPU-1:0] CPU_RUN;
  logic            BUSY;
  logic [NCPU-1:0] FAULT;

  modport master (
    input  REQ_RESET, REQ_ALL, CPU_READY,
    output CPU_RESET, CPU_START, CPU_RUN, BUSY, FAULT
  );

  modport slave (
    output REQ_RESET, REQ_ALL, CPU_READY,
    input  CPU_RESET, CPU_START, CPU_RUN, BUSY, FAULT
  );
endinterface

// File: rtl/cpu_reset_sequencer_priority.sv
// Lowest-index-first encoder over the pending CPU mask.
module rst_seq_priority
  import cray_reset_pkg::*;
#(
  parameter int unsigned NCPU = DEF_NCPU,
  localparam int unsigned IDX_W = idx_width(NCPU)
) (
  input  logic [NCPU-1:0]  mask,
  output logic [IDX_W-1:0] idx,
  output logic             valid
);

  logic [NCPU-1:0] low;

  // Isolate the lowest set bit, then encode its position.
  assign low   = mask & (~mask + NCPU'(1));
  assign valid = |mask;

  // Map the one-hot lowest bit to its index.
  always_comb begin
    idx = '0;
    for (int unsigned i = 0; i < NCPU; i++) begin
      if (low == (NCPU'(1) << i)) idx = IDX_W'(i);
    end
  end

endmodule

// File: rtl/cpu_reset_sequencer.sv
// Per-CPU reset release and deadstart sequencer.
// Holds requested CPUs in reset, releases them lowest index first,
// pulses CPU_START and waits for CPU_READY with a timeout.
// Optional: CPU_RESET_RETRY_EN gives each CPU one retry before FAULT.
module cpu_reset_sequencer
  import cray_reset_pkg::*;
#(
  parameter int unsigned NCPU        = DEF_NCPU,
  parameter int unsigned HOLD_CYCLES = DEF_HOLD_CYCLES,
  parameter int unsigned GAP_CYCLES  = DEF_GAP_CYCLES,
  parameter int unsigned ACK_TIMEOUT = DEF_ACK_TIMEOUT
) (
  input  logic                  SYSTEM_CLOCK,
  input  logic                  SYSTEM_RESET,
  cpu_reset_sequencer_if.master bus
);

  localparam int unsigned CNT_W = cnt_width(HOLD_CYCLES, GAP_CYCLES, ACK_TIMEOUT);
  localparam int unsigned IDX_W = idx_width(NCPU);
  localparam logic [CNT_W-1:0] HOLD_LD = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LD  = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] ACK_LD  = CNT_W'(ACK_TIMEOUT - 1);

`ifdef CPU_RESET_RETRY_EN
  localparam bit RETRY_EN = 1'b1;
`else
  localparam bit RETRY_EN = 1'b0;
`endif

  seq_state_e       state_q, state_d;
  logic [IDX_W-1:0] cur_q, cur_d, sel_idx;
  logic             sel_valid;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             retry_q, retry_d;
  logic [NCPU-1:0]  pend_q, pend_d;
  logic [NCPU-1:0]  rst_q, rst_d;
  logic [NCPU-1:0]  start_q, start_d;
  logic [NCPU-1:0]  run_q, run_d;
  logic [NCPU-1:0]  fault_q, fault_d;
  logic [NCPU-1:0]  req;

  rst_seq_priority #(.NCPU(NCPU)) u_prio (
    .mask  (pend_q),
    .idx   (sel_idx),
    .valid (sel_valid)
  );

  assign req           = bus.REQ_RESET | {NCPU{bus.REQ_ALL}};
  assign bus.CPU_RESET = rst_q;
  assign bus.CPU_START = start_q;
  assign bus.CPU_RUN   = run_q;
  assign bus.FAULT     = fault_q;
  assign bus.BUSY      = (state_q != IDLE) || (|pend_q);

  // Next-state and output decode; requests are merged last so they win.
  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    cnt_d   = cnt_q;
    retry_d = retry_q;
    pend_d  = pend_q;
    rst_d   = rst_q;
    start_d = '0;
    run_d   = run_q;
    fault_d = fault_q;

    unique case (state_q)
      IDLE: begin
        if (|pend_q) state_d = SELECT;
      end
      SELECT: begin
        // REQ_ALL here restarts selection from the refreshed mask.
        if (!bus.REQ_ALL) begin
          if (sel_valid) begin
            cur_d           = sel_idx;
            pend_d[sel_idx] = 1'b0;
            cnt_d           = HOLD_LD;
            retry_d         = 1'b0;
            state_d         = HOLD;
          end else begin
            state_d = IDLE;
          end
        end
      end
      HOLD: begin
        if (bus.REQ_ALL) begin
          state_d = SELECT;
        end else if (cnt_q == '0) begin
          rst_d[cur_q] = 1'b0;
          cnt_d        = GAP_LD;
          state_d      = GAP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      GAP: begin
        if (req[cur_q]) begin
          state_d = SELECT;
        end else if (cnt_q == '0) begin
          start_d[cur_q] = 1'b1;
          cnt_d          = ACK_LD;
          state_d        = WAIT;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      WAIT: begin
        if (req[cur_q]) begin
          state_d = SELECT;
        end else if (bus.CPU_READY[cur_q]) begin
          run_d[cur_q]   = 1'b1;
          fault_d[cur_q] = 1'b0;
          state_d        = SELECT;
        end else if (cnt_q == '0) begin
          rst_d[cur_q] = 1'b1;
          if (RETRY_EN && !retry_q) begin
            retry_d = 1'b1;
            cnt_d   = HOLD_LD;
            state_d = HOLD;
          end else begin
            fault_d[cur_q] = 1'b1;
            state_d        = SELECT;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = SELECT;
    endcase

    pend_d = pend_d | req;
    rst_d  = rst_d | req;
    run_d  = run_d & ~req;
  end

  // State and output registers; reset holds every CPU pending in reset.
  always_ff @(posedge SYSTEM_CLOCK or posedge SYSTEM_RESET) begin
    if (SYSTEM_RESET) begin
      state_q <= SELECT;
      cur_q   <= '0;
      cnt_q   <= '0;
      retry_q <= 1'b0;
      pend_q  <= '1;
      rst_q   <= '1;
      start_q <= '0;
      run_q   <= '0;
      fault_q <= '0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      cnt_q   <= cnt_d;
      retry_q <= retry_d;
      pend_q  <= pend_d;
      rst_q   <= rst_d;
      start_q <= start_d;
      run_q   <= run_d;
      fault_q <= fault_d;
    end
  end

endmodule

// File: tb/tb_cpu_reset_sequencer.sv
// Scoreboard bench for cpu_reset_sequencer (NCPU=4, HOLD=8, GAP=4, ACK_TIMEOUT=16).
// Expected CPU_START events are queued by the stimulus; a monitor pops one per pulse.
module tb_cpu_reset_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cpu_reset_sequencer_if #(.NCPU(4)) bus ();

  cpu_reset_sequencer #(
    .NCPU        (4),
    .HOLD_CYCLES (8),
    .GAP_CYCLES  (4),
    .ACK_TIMEOUT (16)
  ) dut (
    .SYSTEM_CLOCK (clk),
    .SYSTEM_RESET (rst),
    .bus          (bus)
  );

  typedef struct {
    logic [3:0] start;
    logic [3:0] rst_mask;
    int         cyc;
  } exp_t;

  exp_t       sb[$];
  exp_t       mon_e;
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         base;
  logic [3:0] rdy = '0;
  logic [3:0] noack = '0;
  int         tmr[4] = '{default: 0};
  int         nstart[4] = '{default: 0};
  int         need[4] = '{default: 1};

  assign bus.CPU_READY = rdy;

  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic push(input logic [3:0] s, input logic [3:0] r, input int c);
    exp_t e;
    e.start    = s;
    e.rst_mask = r;
    e.cyc      = c;
    sb.push_back(e);
  endtask

  // CPU model: acks 3 cycles after START unless masked or not yet on its needed attempt.
  always @(negedge clk) begin
    if (rst) begin
      rdy = '0;
      for (int i = 0; i < 4; i++) begin
        tmr[i]    = 0;
        nstart[i] = 0;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        rdy[i] = 1'b0;
        if (tmr[i] != 0) begin
          tmr[i]--;
          if (tmr[i] == 0) rdy[i] = 1'b1;
        end
        if (bus.CPU_START[i]) begin
          nstart[i]++;
          if (!noack[i] && nstart[i] >= need[i]) tmr[i] = 3;
        end
      end
    end
  end

  // Monitor: every START pulse is matched against the next queued expectation.
  always @(negedge clk) begin
    if (!rst && bus.CPU_START != 4'b0000) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_start: got %b expected none (cycle %0d)", bus.CPU_START, cyc);
      end else begin
        mon_e = sb.pop_front();
        check("start_mask", bus.CPU_START, mon_e.start);
        check("start_cpu_reset", bus.CPU_RESET, mon_e.rst_mask);
        check_int("start_cycle", cyc, mon_e.cyc);
      end
    end
  end

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.REQ_RESET = '0;
    bus.REQ_ALL = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rst_cpu_reset", bus.CPU_RESET, 4'b1111);
    check("rst_cpu_start", bus.CPU_START, 4'b0000);
    check("rst_cpu_run", bus.CPU_RUN, 4'b0000);
    check("rst_fault", bus.FAULT, 4'b0000);
    check("rst_busy", {3'b000, bus.BUSY}, 4'b0001);
    rst = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int lim);
    int n;
    n = 0;
    @(negedge clk);
    while (bus.BUSY && n < lim) begin
      @(negedge clk);
      n++;
    end
    check({name, "_busy"}, {3'b000, bus.BUSY}, 4'b0000);
    check_int({name, "_sb_drained"}, sb.size(), 0);
    sb.delete();
  endtask

  task automatic wait_cyc(input string name, input int target);
    int n;
    n = 0;
    while (cyc != target && n < 500) begin
      @(negedge clk);
      n++;
    end
    check_int(name, cyc, target);
  endtask

  initial begin
    bus.REQ_RESET = '0;
    bus.REQ_ALL = 1'b0;

    // Power-up: CPUs 0..3 released in order, first START 13 edges after reset.
    push(4'b0001, 4'b1110, 13);
    push(4'b0010, 4'b1100, 30);
    push(4'b0100, 4'b1000, 47);
    push(4'b1000, 4'b0000, 64);
    apply_reset();
    wait_idle("t1", 200);
    check("t1_run", bus.CPU_RUN, 4'b1111);
    check("t1_fault", bus.FAULT, 4'b0000);
    check("t1_cpu_reset", bus.CPU_RESET, 4'b0000);

    // Concurrent requests while idle: CPU1 before CPU3, CPU0/CPU2 untouched.
    @(negedge clk);
    base = cyc;
    push(4'b0010, 4'b1000, base + 15);
    push(4'b1000, 4'b0000, base + 32);
    bus.REQ_RESET = 4'b1010;
    @(negedge clk);
    bus.REQ_RESET = '0;
    check("t3_cpu_reset", bus.CPU_RESET, 4'b1010);
    check("t3_run", bus.CPU_RUN, 4'b0101);
    wait_idle("t3", 200);
    check("t3_run_end", bus.CPU_RUN, 4'b1111);

    // Timeout: CPU2 never acks.
    noack = 4'b0100;
    push(4'b0001, 4'b1110, 13);
    push(4'b0010, 4'b1100, 30);
    push(4'b0100, 4'b1000, 47);
`ifdef CPU_RESET_RETRY_EN
    push(4'b0100, 4'b1000, 75);
    push(4'b1000, 4'b0100, 104);
`else
    push(4'b1000, 4'b0100, 76);
`endif
    apply_reset();
    wait_idle("t2", 300);
    check("t2_fault", bus.FAULT, 4'b0100);
    check("t2_cpu_reset", bus.CPU_RESET, 4'b0100);
    check("t2_run", bus.CPU_RUN, 4'b1011);

    // Mid-sequence SYSTEM_RESET while CPU0 is in GAP.
    noack = '0;
    @(negedge clk);
    base = cyc;
    bus.REQ_RESET = 4'b0001;
    @(negedge clk);
    bus.REQ_RESET = '0;
    check("t5_cpu_reset_req", bus.CPU_RESET, 4'b0101);
    wait_cyc("t5_reach_gap", base + 13);
    check("t5_cpu_reset_gap", bus.CPU_RESET, 4'b0100);
    check("t5_fault_before", bus.FAULT, 4'b0100);
    #1 rst = 1'b1;
    #1;
    check("t5_async_cpu_reset", bus.CPU_RESET, 4'b1111);
    check("t5_async_start", bus.CPU_START, 4'b0000);
    check("t5_async_run", bus.CPU_RUN, 4'b0000);
    check("t5_async_fault", bus.FAULT, 4'b0000);
    check("t5_async_busy", {3'b000, bus.BUSY}, 4'b0001);

    // Abort: REQ_ALL while CPU1 waits for ready; restart from CPU0.
    push(4'b0001, 4'b1110, 13);
    push(4'b0010, 4'b1100, 30);
    push(4'b0001, 4'b1110, 45);
    push(4'b0010, 4'b1100, 62);
    push(4'b0100, 4'b1000, 79);
    push(4'b1000, 4'b0000, 96);
    apply_reset();
    wait_cyc("t4_reach_wait", 31);
    bus.REQ_ALL = 1'b1;
    @(negedge clk);
    bus.REQ_ALL = 1'b0;
    check("t4_cpu_reset_all", bus.CPU_RESET, 4'b1111);
    check("t4_run_cleared", bus.CPU_RUN, 4'b0000);
    wait_idle("t4", 300);
    check("t4_run", bus.CPU_RUN, 4'b1111);
    check("t4_fault", bus.FAULT, 4'b0000);

`ifdef CPU_RESET_RETRY_EN
    // Retry: CPU1 acks only on its second START.
    need = '{1, 2, 1, 1};
    push(4'b0001, 4'b1110, 13);
    push(4'b0010, 4'b1100, 30);
    push(4'b0010, 4'b1100, 58);
    push(4'b0100, 4'b1000, 75);
    push(4'b1000, 4'b0000, 92);
    apply_reset();
    wait_idle("t6", 300);
    check("t6_fault", bus.FAULT, 4'b0000);
    check("t6_run", bus.CPU_RUN, 4'b1111);
    check_int("t6_cpu1_starts", nstart[1], 2);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (errors=%0d)", errors);
    $fatal(1);
  end

endmodule

// File: doc/cpu_reset_sequencer.md
Name: cpu_reset_sequencer

Overview:
- Sequences per-CPU reset release and deadstart after system reset, and on later per-CPU or all-CPU reset requests from the maintenance channel.
- Holds every requested CPU in CPU_RESET, then releases CPUs one at a time, lowest index first.
- After each release, issues a one-cycle CPU_START and waits for that CPU's CPU_READY, with a timeout.
- Sits between the system reset generator and the CPU array.

Parameters:
- NCPU, 4: number of CPUs sequenced, 1..16.
- HOLD_CYCLES, 8: minimum cycles CPU_RESET is held for the CPU being serviced, 2..255.
- GAP_CYCLES, 4: cycles from CPU_RESET release to CPU_START, 1..255.
- ACK_TIMEOUT, 255: cycles to wait for CPU_READY after CPU_START, 1..65535.

Ports:
- SYSTEM_CLOCK  in  1  system clock; all logic on posedge.
- SYSTEM_RESET  in  1  asynchronous, active-high reset.
- REQ_RESET  in  NCPU  per-CPU reset request, level; sampled every cycle.
- REQ_ALL  in  1  reset-all request, level.
- CPU_RESET  out  NCPU  per-CPU reset, active high, registered.
- CPU_START  out  NCPU  one-cycle deadstart pulse, registered.
- CPU_READY  in  NCPU  CPU acknowledges deadstart complete.
- CPU_RUN  out  NCPU  CPU released and acknowledged.
- BUSY  out  1  sequencer not IDLE, or pending mask nonzero.
- FAULT  out  NCPU  sticky: CPU failed to acknowledge within ACK_TIMEOUT.

Behaviour:
- Async reset values:
  - CPU_RESET = all 1; pending = all 1; CPU_RUN = 0; CPU_START = 0; FAULT = 0.
  - State = SELECT; counter = 0; BUSY = 1.
- Request capture, every cycle:
  - pending |= REQ_RESET | {NCPU{REQ_ALL}}.
  - For every newly set bit: CPU_RESET = 1 and CPU_RUN = 0 on the next edge.
  - A CPU in reset stays in reset until its turn.
- States:
  - IDLE: if pending != 0 -> SELECT.
  - SELECT: cur = lowest-index set pending bit; clear that bit; counter = HOLD_CYCLES-1 -> HOLD. If pending == 0 -> IDLE.
  - HOLD: CPU_RESET[cur] = 1. When counter == 0: CPU_RESET[cur] = 0, counter = GAP_CYCLES-1 -> GAP. Otherwise decrement.
  - GAP: when counter == 0: CPU_START[cur] = 1 for one cycle, counter = ACK_TIMEOUT-1 -> WAIT. Otherwise decrement.
  - WAIT:
    - CPU_READY[cur] = 1: CPU_RUN[cur] = 1, FAULT[cur] = 0 -> SELECT.
    - Otherwise, counter == 0: FAULT[cur] = 1, CPU_RESET[cur] = 1 (CPU held in reset) -> SELECT.
- Re-request of cur during HOLD, GAP or WAIT:
  - Sets pending[cur].
  - In GAP or WAIT, CPU_RESET[cur] reasserts immediately and the sequence aborts to SELECT next cycle.
  - In HOLD, the sequence continues, then cur is served again later.
- REQ_ALL while busy: all CPUs to reset and pending; current sequence aborts to SELECT.
- CPU_READY from a non-cur CPU is ignored.
- Latency to first CPU_START after SYSTEM_RESET deassert (CPU0): 1 + HOLD_CYCLES + GAP_CYCLES edges.
- Counters are sized to the largest parameter and never wrap; checked with a zero compare.
- SYSTEM_RESET mid-sequence restores the reset values immediately (asynchronous).

Optional Feature:
- CPU_RESET_RETRY_EN:
  - Defined: the first timeout on a CPU re-enters HOLD for that CPU once (retry flag per sequence). FAULT is set only on the second timeout.
  - Undefined: the first timeout sets FAULT and the sequencer moves on.

Decomposition:
- Shared package cray_reset_pkg:
  - State encoding: IDLE, SELECT, HOLD, GAP, WAIT.
  - Default timing constants (HOLD_CYCLES, GAP_CYCLES, ACK_TIMEOUT).
  - Counter width function (clog2 of the maximum parameter).
- Sub-module rst_seq_priority: combinational lowest-index-first encoder. Input NCPU-bit mask; outputs index and valid.

Test Plan:
- Power-up, NCPU=4, defaults, CPUs ack 3 cycles after START:
  - CPU_RESET=1111 during reset.
  - CPU0 START at edge 13 after reset deassert; CPUs released in order 0,1,2,3.
  - CPU_RUN=1111; BUSY=0.
- Timeout: CPU2 never acks, ACK_TIMEOUT=16:
  - FAULT=0100; CPU_RESET[2] stays 1; CPU3 still sequenced; CPU_RUN=1011.
- Concurrent requests while idle: REQ_RESET=1010 for 1 cycle:
  - CPU_RESET=1010 next edge; CPU1 served before CPU3; CPU0 and CPU2 unaffected.
- Abort: REQ_ALL pulsed while CPU1 is in WAIT:
  - All CPU_RESET=1 next edge; sequence restarts at CPU0.
- Mid-sequence reset: SYSTEM_RESET asserted during GAP:
  - Outputs take reset values without a clock edge; FAULT cleared.
- With CPU_RESET_RETRY_EN, CPU1 acks only on its second attempt:
  - Exactly two START pulses to CPU1; FAULT=0000; CPU_RUN[1]=1.
